coord_stream_buffer: RTL and testbench

- Sits directly downstream of the coordinate collector and upstream of the pathfinding core.
- Captures each committed (x, y) pair from the collector's write strobe into an internal buffer during the collection phase.
- Once the collector signals completion, replays the stored pairs in entry order to the core over a valid/ready stream, then holds a terminal done state until reset.

---
 rtl/coord_stream_buffer_if.sv | 13 +
 rtl/coord_stream_buffer.sv | 123 ++++++++++++
 tb/tb_coord_stream_buffer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/coord_stream_buffer_if.sv
// Coordinate replay stream: buffer (master) presents (x, y) pairs to the pathfinding core (slave).
interface coord_stream_buffer_if #(
   parameter int unsigned COORD_W = 8
) ();
   logic               out_valid;
   logic               out_ready;
   logic               out_last;
   logic [COORD_W-1:0] out_x;
   logic [COORD_W-1:0] out_y;

   modport master (output out_valid, output out_x, output out_y, output out_last, input out_ready);
   modport slave  (input out_valid, input out_x, input out_y, input out_last, output out_ready);
endinterface

// File: rtl/coord_stream_buffer.sv
// Captures collector (x, y) commits on the write-strobe falling edge, then replays them in order.
// Optional grid bounds filtering is compiled in with `define COORD_BOUNDS_CHECK_EN.
module coord_stream_buffer #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned COORD_W = 8,
   parameter int unsigned GRID_W  = 32,
   parameter int unsigned GRID_H  = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [COORD_W-1:0]  coord_x_in,
   input  logic [COORD_W-1:0]  coord_y_in,
   input  logic                coord_wren_in,
   input  logic                collect_done_in,
   coord_stream_buffer_if.master stream,
   output logic [ADDR_W:0]     count,
   output logic                overflow,
   output logic                oob_err,
   output logic                stream_done
);

   localparam int unsigned ENTRY_W   = 2 * COORD_W;
   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {COLLECT, STREAM, DONE} state_t;

   state_t               state;
   logic                 wren_q;
   logic [ADDR_W-1:0]    wr_ptr;
   logic [ADDR_W:0]      rd_ptr;
   logic [ENTRY_W-1:0]   mem [DEPTH];

   logic                 commit_c;
   logic                 full_c;
   logic                 oob_c;
   logic                 drop_oob_c;
   logic                 store_c;
   logic [ENTRY_W-1:0]   rd_data_c;

`ifdef COORD_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;

   // Sticky record of any out-of-grid commit seen while collecting.
   always_ff @(posedge clk) begin
      if (reset) begin
         oob_err <= 1'b0;
      end else if (commit_c && oob_c) begin
         oob_err <= 1'b1;
      end
   end
`else
   localparam bit BOUNDS_EN = 1'b0;

   assign oob_err = 1'b0;
`endif

   assign commit_c   = (state == COLLECT) && wren_q && !coord_wren_in;
   assign full_c     = (count == DEPTH_CNT);
   assign oob_c      = (32'(coord_x_in) >= GRID_W) || (32'(coord_y_in) >= GRID_H);
   assign drop_oob_c = oob_c && BOUNDS_EN;
   assign store_c    = commit_c && !full_c && !drop_oob_c;
   assign rd_data_c  = mem[rd_ptr[ADDR_W-1:0]];

   // Entry storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (store_c) begin
         mem[wr_ptr] <= {coord_x_in, coord_y_in};
      end
   end

   // Control FSM; rd_ptr always points at the next entry to load into the output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= COLLECT;
         wren_q           <= 1'b0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         overflow         <= 1'b0;
         stream_done      <= 1'b0;
         stream.out_valid <= 1'b0;
         stream.out_x     <= '0;
         stream.out_y     <= '0;
         stream.out_last  <= 1'b0;
      end else begin
         wren_q <= coord_wren_in;
         case (state)
            COLLECT: begin
               if (store_c) begin
                  wr_ptr <= wr_ptr + ADDR_W'(1);
                  count  <= count + (ADDR_W+1)'(1);
               end
               if (commit_c && full_c) begin
                  overflow <= 1'b1;
               end
               if (collect_done_in) begin
                  state <= STREAM;
               end
            end
            STREAM: begin
               if (!stream.out_valid || stream.out_ready) begin
                  if (rd_ptr == count) begin
                     stream.out_valid <= 1'b0;
                     stream.out_last  <= 1'b0;
                     stream_done      <= 1'b1;
                     state            <= DONE;
                  end else begin
                     stream.out_valid <= 1'b1;
                     stream.out_x     <= rd_data_c[ENTRY_W-1 -: COORD_W];
                     stream.out_y     <= rd_data_c[COORD_W-1:0];
                     stream.out_last  <= ((rd_ptr + (ADDR_W+1)'(1)) == count);
                     rd_ptr           <= rd_ptr + (ADDR_W+1)'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coord_stream_buffer.sv
// Randomized self-checking bench for coord_stream_buffer against a queue-based reference model.
module tb_coord_stream_buffer;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned COORD_W = 8;
   localparam int unsigned GRID_W  = 32;
   localparam int unsigned GRID_H  = 32;
`ifdef COORD_BOUNDS_CHECK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset;
   logic [COORD_W-1:0] cx;
   logic [COORD_W-1:0] cy;
   logic               wren;
   logic               cdone;
   logic [ADDR_W:0]    count;
   logic               overflow;
   logic               oob_err;
   logic               stream_done;

   coord_stream_buffer_if #(.COORD_W(COORD_W)) sif ();

   coord_stream_buffer #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .COORD_W(COORD_W), .GRID_W(GRID_W), .GRID_H(GRID_H)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .coord_x_in      (cx),
      .coord_y_in      (cy),
      .coord_wren_in   (wren),
      .collect_done_in (cdone),
      .stream          (sif.master),
      .count           (count),
      .overflow        (overflow),
      .oob_err         (oob_err),
      .stream_done     (stream_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: entries the buffer must hold, plus expected sticky flags.
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   bit          m_ovf;
   bit          m_oob;
   bit          pat[$];

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wren = 1'b0;
      cdone = 1'b0;
      sif.out_ready = 1'b0;
      cx = '0;
      cy = '0;
      tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
      m_ovf = 1'b0;
      m_oob = 1'b0;
      chk("rst_valid", 32'(sif.out_valid), 0);
      chk("rst_last", 32'(sif.out_last), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_oob", 32'(oob_err), 0);
      chk("rst_done", 32'(stream_done), 0);
   endtask

   // Hold the strobe high for 'hold' cycles; the commit lands when it drops.
   task automatic commit(input logic [7:0] x, input logic [7:0] y, input int hold, input bit with_done);
      bit full;
      bit oob;
      cx = x;
      cy = y;
      wren = 1'b1;
      repeat (hold) tick();
      wren = 1'b0;
      if (with_done) cdone = 1'b1;
      tick();
      full = (exp_q.size() == DEPTH);
      oob  = BOUNDS && ((int'(x) >= int'(GRID_W)) || (int'(y) >= int'(GRID_H)));
      if (full) m_ovf = 1'b1;
      if (oob) m_oob = 1'b1;
      if (!full && !oob) exp_q.push_back({x, y});
      chk("commit_count", 32'(count), 32'(exp_q.size()));
      chk("commit_overflow", 32'(overflow), 32'(m_ovf));
      chk("commit_oob", 32'(oob_err), 32'(m_oob));
      cx = 8'($urandom);
      cy = 8'($urandom);
   endtask

   function automatic bit pick_ready(input int rmode, input int k);
      if (rmode == 0) return pat[k % pat.size()];
      return ($urandom_range(0, 2) != 0);
   endfunction

   // Raise done (unless already raised with the last commit) and check the replay cycle by cycle.
   task automatic run_stream(input bit already, input int rmode);
      int  idx = 0;
      int  n   = exp_q.size();
      int  k   = 0;
      bit  fin = 1'b0;
      bit  rdy;
      got_q.delete();
      if (!already) begin
         cdone = 1'b1;
         tick();
      end
      chk("n1_valid", 32'(sif.out_valid), 0);
      chk("n1_done", 32'(stream_done), 0);
      sif.out_ready = pick_ready(rmode, k++);
      for (int c = 0; c < 400 && !fin; c++) begin
         tick();
         if (idx < n) begin
            chk("str_valid", 32'(sif.out_valid), 1);
            chk("str_x", 32'(sif.out_x), 32'(exp_q[idx][15:8]));
            chk("str_y", 32'(sif.out_y), 32'(exp_q[idx][7:0]));
            chk("str_last", 32'(sif.out_last), 32'(idx == n - 1));
            chk("str_done", 32'(stream_done), 0);
         end else begin
            chk("end_valid", 32'(sif.out_valid), 0);
            chk("end_last", 32'(sif.out_last), 0);
            chk("end_done", 32'(stream_done), 1);
            fin = 1'b1;
         end
         chk("str_count", 32'(count), 32'(n));
         rdy = pick_ready(rmode, k++);
         sif.out_ready = rdy;
         if (!fin && rdy) begin
            got_q.push_back({sif.out_x, sif.out_y});
            idx++;
         end
      end
      if (!fin) chk("stream_timeout", 0, 1);
      tick();
      chk("done_hold", 32'(stream_done), 1);
      chk("done_valid", 32'(sif.out_valid), 0);
   endtask

   initial begin
      int n;
      bit wd;

      // Basic three-entry replay with a consumer that is always ready.
      do_reset();
      commit(8'd3, 8'd5, 4, 1'b0);
      commit(8'd10, 8'd2, 4, 1'b0);
      commit(8'd0, 8'd31, 4, 1'b0);
      chk("t1_count_lit", 32'(count), 3);
      pat = '{1'b1};
      run_stream(1'b0, 0);
      chk("t1_ntx_lit", 32'(got_q.size()), 3);
      chk("t1_first_lit", 32'(got_q[0]), 32'(16'h0305));
      chk("t1_last_lit", 32'(got_q[2]), 32'(16'h001F));

      // Same entries under a stalling consumer.
      do_reset();
      commit(8'd3, 8'd5, 4, 1'b0);
      commit(8'd10, 8'd2, 4, 1'b0);
      commit(8'd0, 8'd31, 4, 1'b0);
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      run_stream(1'b0, 0);
      chk("t2_ntx_lit", 32'(got_q.size()), 3);
      chk("t2_mid_lit", 32'(got_q[1]), 32'(16'h0A02));

      // Seventeen commits into a sixteen-entry buffer.
      do_reset();
      for (int i = 0; i < 17; i++) commit(8'(i + 1), 8'(i), 2, 1'b0);
      chk("t3_count_lit", 32'(count), 16);
      chk("t3_ovf_lit", 32'(overflow), 1);
      run_stream(1'b0, 1);
      chk("t3_ntx_lit", 32'(got_q.size()), 16);
      chk("t3_tail_lit", 32'(got_q[15]), 32'(16'h100F));

      // Done with nothing collected.
      do_reset();
      run_stream(1'b0, 1);
      chk("t4_count_lit", 32'(count), 0);
      chk("t4_ntx_lit", 32'(got_q.size()), 0);

      // Reset mid-stream after one of three transfers.
      do_reset();
      commit(8'd3, 8'd5, 4, 1'b0);
      commit(8'd10, 8'd2, 4, 1'b0);
      commit(8'd0, 8'd31, 4, 1'b0);
      cdone = 1'b1;
      tick();
      sif.out_ready = 1'b1;
      tick();
      chk("t5_first_valid", 32'(sif.out_valid), 1);
      chk("t5_first_x", 32'(sif.out_x), 3);
      tick();
      chk("t5_second_x", 32'(sif.out_x), 10);
      reset = 1'b1;
      cdone = 1'b0;
      sif.out_ready = 1'b0;
      tick();
      chk("t5_rst_valid", 32'(sif.out_valid), 0);
      chk("t5_rst_count", 32'(count), 0);
      chk("t5_rst_done", 32'(stream_done), 0);
      reset = 1'b0;
      exp_q.delete();
      m_ovf = 1'b0;
      m_oob = 1'b0;
      commit(8'd7, 8'd9, 2, 1'b0);
      chk("t5_new_count_lit", 32'(count), 1);
      run_stream(1'b0, 1);

      // Out-of-grid value followed by an in-grid value.
      do_reset();
      commit(8'd40, 8'd1, 3, 1'b0);
      commit(8'd4, 8'd4, 3, 1'b0);
      chk("t6_count_lit", 32'(count), BOUNDS ? 1 : 2);
      chk("t6_oob_lit", 32'(oob_err), 32'(BOUNDS));
      pat = '{1'b1};
      run_stream(1'b0, 0);
      chk("t6_first_lit", 32'(got_q[0]), BOUNDS ? 32'(16'h0404) : 32'(16'h2801));

      // Randomized rounds, sometimes raising done in the same cycle as the last commit.
      for (int r = 0; r < 8; r++) begin
         do_reset();
         n  = $urandom_range(0, 19);
         wd = 1'b0;
         for (int i = 0; i < n; i++) begin
            if (i == n - 1) wd = ($urandom_range(0, 1) == 1);
            commit(8'($urandom), 8'($urandom), $urandom_range(1, 4), wd);
            if (!wd) repeat ($urandom_range(0, 2)) tick();
         end
         run_stream(wd, 1);
         chk("rnd_ntx", 32'(got_q.size()), 32'(exp_q.size()));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
